// File: rtl/program_mem_controller_if.sv
// Program-memory read bus between the per-core fetchers, the controller and
// the external program memory.
//
// Signals (flat vectors, one slice per fetcher / per memory channel):
//   consumer_read_valid   [NUM_CONSUMERS]            fetcher request
//   consumer_read_address [NUM_CONSUMERS*ADDR_BITS]  fetcher request address
//   consumer_read_ready   [NUM_CONSUMERS]            response strobe to fetcher
//   consumer_read_data    [NUM_CONSUMERS*DATA_BITS]  instruction word to fetcher
//   mem_read_valid        [NUM_CHANNELS]             request to program memory
//   mem_read_address      [NUM_CHANNELS*ADDR_BITS]   address to program memory
//   mem_read_ready        [NUM_CHANNELS]             memory response strobe
//   mem_read_data         [NUM_CHANNELS*DATA_BITS]   memory response word
//
// Handshake: a requester raises valid with a stable address and holds both
// until the responder pulses ready for exactly one cycle; the data slice is
// meaningful on the ready cycle. The requester drops valid afterwards (a
// fetcher may lag by a cycle), and a valid that stays high after its ready
// pulse is not a new request.
//
// Modports: slave  = the controller (answers fetchers, issues memory reads)
//           master = the fetchers plus program memory around it
interface program_mem_controller_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CHANNELS-1:0]            mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]            mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;

  modport slave (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

  modport master (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/program_mem_controller.sv
// Program-memory read controller: arbitrates NUM_CONSUMERS fetcher read
// requests onto NUM_CHANNELS memory read channels and relays each returned
// instruction word back to the fetcher that asked for it.
//
// Ports:
//   clk          in   clock, everything on posedge
//   reset        in   synchronous, active-high
//   bus          slave modport of program_mem_controller_if (fetcher and
//                memory handshakes, all outputs registered)
//   dbg_state_o  out  per-channel FSM state (0 IDLE, 1 READ_WAITING, 2 RELAYING)
module program_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  program_mem_controller_if.slave       bus,
  output logic [NUM_CHANNELS-1:0][1:0]  dbg_state_o
);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    READ_WAITING = 2'd1,
    RELAYING     = 2'd2
  } state_e;

  state_e                                  state_q [NUM_CHANNELS];
  state_e                                  state_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][CW-1:0]         owner_q, owner_d;
  logic [NUM_CHANNELS-1:0][CW-1:0]         rr_q, rr_d;
  logic [NUM_CHANNELS-1:0]                 mem_valid_q, mem_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [NUM_CONSUMERS-1:0]                cons_ready_q, cons_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_data_q, cons_data_d;
  logic [NUM_CONSUMERS-1:0]                in_service_q, in_service_d;

  assign bus.mem_read_valid      = mem_valid_q;
  assign bus.mem_read_address    = mem_addr_q;
  assign bus.consumer_read_ready = cons_ready_q;
  assign bus.consumer_read_data  = cons_data_q;

  always_comb begin
    dbg_state_o = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      dbg_state_o[ch] = state_q[ch];
    end
  end

  always_comb begin
    // taken: consumers already owned by some channel, plus those claimed by a
    // lower-numbered channel earlier in this same evaluation.
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    int                       pick;
    int                       idx;
    int                       owner;

    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
    end
    owner_d      = owner_q;
    rr_d         = rr_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    cons_ready_d = '0;            // ready is a single-cycle pulse
    cons_data_d  = cons_data_q;
    in_service_d = in_service_q;
    taken        = in_service_q;
    found        = 1'b0;
    pick         = 0;
    idx          = 0;
    owner        = 0;

    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      owner = int'(owner_q[ch]);
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          pick  = 0;
          // Round-robin scan starting at this channel's pointer.
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = int'(rr_q[ch]) + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            if (!found && bus.consumer_read_valid[idx] && !taken[idx]) begin
              found = 1'b1;
              pick  = idx;
            end
          end
          if (found) begin
            taken[pick]        = 1'b1;
            in_service_d[pick] = 1'b1;
            owner_d[ch]        = CW'(pick);
            mem_valid_d[ch]    = 1'b1;
            mem_addr_d[ch]     = bus.consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
            rr_d[ch]           = (pick == NUM_CONSUMERS - 1) ? '0 : CW'(pick + 1);
            state_d[ch]        = READ_WAITING;
          end
        end
        READ_WAITING: begin
          // No timeout: the request is held until memory answers.
          if (bus.mem_read_ready[ch]) begin
            mem_valid_d[ch]     = 1'b0;
            cons_data_d[owner]  = bus.mem_read_data[ch*DATA_BITS +: DATA_BITS];
            cons_ready_d[owner] = 1'b1;
            state_d[ch]         = RELAYING;
          end
        end
        RELAYING: begin
          // Wait for the fetcher to drop valid so a lagging valid is not
          // mistaken for a fresh request.
          if (!bus.consumer_read_valid[owner]) begin
            in_service_d[owner] = 1'b0;
            state_d[ch]         = IDLE;
          end
        end
        default: begin
          state_d[ch] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
      end
      owner_q      <= '0;
      rr_q         <= '0;
      mem_valid_q  <= '0;
      mem_addr_q   <= '0;
      cons_ready_q <= '0;
      cons_data_q  <= '0;
      in_service_q <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
      end
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      cons_ready_q <= cons_ready_d;
      cons_data_q  <= cons_data_d;
      in_service_q <= in_service_d;
    end
  end
endmodule
